// File: rtl/sqrt_request_arbiter_if.sv
// Client/engine handshake bundle for the shared square-root arbiter.
// master = arbiter side, slave = requesters plus engine (or a bench standing in for them).
interface sqrt_request_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ-1:0]       gnt;
    logic                     eng_start;
    logic [WIDTH-1:0]         eng_x;
    logic                     eng_done;
    logic [WIDTH-1:0]         eng_sqrt;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sqrt;
    logic                     rsp_err;
    logic                     busy;

    modport master (
        input  req, req_x, eng_done, eng_sqrt,
        output gnt, eng_start, eng_x, rsp_valid, rsp_id, rsp_sqrt, rsp_err, busy
    );

    modport slave (
        output req, req_x, eng_done, eng_sqrt,
        input  gnt, eng_start, eng_x, rsp_valid, rsp_id, rsp_sqrt, rsp_err, busy
    );
endinterface

// File: rtl/sqrt_request_arbiter.sv
// Round-robin arbiter sharing one integer square-root engine among NUM_REQ clients.
// One job at a time: grant, start engine, wait for done (or time out), respond.
module sqrt_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic Clock,
    input  logic Reset,
    sqrt_request_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    logic [1:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  cur_id;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  sel_id;
    logic             sel_vld;
    logic [WIDTH-1:0] sel_x;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Scan downward so the last hit written is the nearest one at or above ptr.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[wrap_add(ptr, k)]) begin
                sel_vld = 1'b1;
                sel_id  = wrap_add(ptr, k);
            end
        end
    end

    assign sel_x    = bus.req_x[sel_id*WIDTH +: WIDTH];
    assign bus.busy = (state != S_IDLE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= S_IDLE;
            ptr           <= '0;
            cur_id        <= '0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.eng_start <= 1'b0;
            bus.eng_x     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sqrt  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.gnt       <= '0;
            bus.eng_start <= 1'b0;
            bus.rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        bus.gnt       <= NUM_REQ'(1) << sel_id;
                        bus.eng_start <= 1'b1;
                        bus.eng_x     <= sel_x;
                        cur_id        <= sel_id;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                // done is checked first so it wins over the last timeout cycle
                S_WAIT: begin
                    if (bus.eng_done) begin
                        bus.rsp_sqrt  <= bus.eng_sqrt;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_id    <= cur_id;
                        bus.rsp_valid <= 1'b1;
                        state         <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus.rsp_sqrt  <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_id    <= cur_id;
                        bus.rsp_valid <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    ptr   <= (cur_id == ID_LAST) ? '0 : cur_id + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_request_arbiter.sv
// Bench for sqrt_request_arbiter: directed job table, reset/corner sequences and a
// randomized run scored against a round-robin reference model with a simple engine model.
module tb_sqrt_request_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;
    localparam int IW = $clog2(N);

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    sqrt_request_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus();

    sqrt_request_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req_v);
        end
    endtask

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] rq, input int p);
        for (int k = 0; k < N; k++)
            if (rq[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Engine model: done pulse 'delay' cycles after the START cycle; 0 = never.
    int eng_delay  = 0;
    bit eng_early  = 1'b0;
    bit eng_rnd    = 1'b0;
    int last_delay = 0;

    initial begin : engine
        int pend;
        logic [W-1:0] res;
        pend = 0;
        res  = '0;
        bus.eng_done = 1'b0;
        bus.eng_sqrt = '0;
        forever begin
            @(posedge Clock); #1;
            bus.eng_done = 1'b0;
            if (!Reset) pend = 0;
            else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.eng_done = 1'b1;
                        bus.eng_sqrt = res;
                    end
                end
                if (bus.eng_start) begin
                    res = W'(isqrt(int'(bus.eng_x)));
                    last_delay = eng_rnd ? (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8)))
                                         : eng_delay;
                    pend = last_delay;
                    if (eng_early) begin
                        bus.eng_done = 1'b1;
                        bus.eng_sqrt = 8'hAA;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] x;
        int             delay;
        bit             early;
        logic [N-1:0]   egnt;
        int             ex;
        int             eid;
        int             esq;
        bit             eerr;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] rq, input int x3, input int x2, input int x1,
                                input int x0, input int d, input bit e, input logic [N-1:0] g,
                                input int ex, input int eid, input int esq, input bit er);
        vec_t t;
        t.req = rq;  t.x = {W'(x3), W'(x2), W'(x1), W'(x0)};
        t.delay = d; t.early = e; t.egnt = g;
        t.ex = ex;   t.eid = eid; t.esq = esq; t.eerr = er;
        return t;
    endfunction

    // One job: present req, expect grant, drop granted bit, expect response and its latency.
    task automatic run_row(input string tag, input vec_t t, input bit hold_chk);
        logic [N-1:0]  g;
        logic [W-1:0]  psq;
        logic [IW-1:0] pid;
        int lat, exp_lat;
        bit got, stale;
        psq = bus.rsp_sqrt;
        pid = bus.rsp_id;
        eng_delay = t.delay;
        eng_early = t.early;
        @(posedge Clock); #1;
        bus.req   = t.req;
        bus.req_x = t.x;
        if (hold_chk) begin
            @(negedge Clock);
            check({tag, "_hold"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_sqrt}, {1'b0, pid, psq});
        end
        got = 1'b0;
        stale = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge Clock);
            if (bus.rsp_valid) stale = 1'b1;
            got = (bus.gnt != '0);
        end
        check({tag, "_gnt"}, bus.gnt, t.egnt);
        check({tag, "_nostale"}, stale, 0);
        check({tag, "_start_busy"}, {bus.eng_start, bus.busy}, 2'b11);
        check({tag, "_engx"}, bus.eng_x, t.ex);
        g = bus.gnt;
        @(posedge Clock); #1;
        bus.req = bus.req & ~g;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge Clock);
            lat++;
            got = bus.rsp_valid;
        end
        exp_lat = (t.delay >= 1 && t.delay <= TO) ? t.delay + 1 : TO + 1;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_id"}, bus.rsp_id, t.eid);
        check({tag, "_sqrt"}, bus.rsp_sqrt, t.esq);
        check({tag, "_err"}, bus.rsp_err, t.eerr);
    endtask

    vec_t tv[13];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [N-1:0] rq, rprev;
        logic [W-1:0] xs[N];
        logic [W-1:0] ox;
        int mptr, oid, ei, d, grants, rsps;
        bit out;

        tv[0]  = mk(4'b1111, 16, 255, 1, 0,  2, 0, 4'b0001,   0, 0,  0, 0);
        tv[1]  = mk(4'b1111, 16, 255, 1, 0,  2, 0, 4'b0010,   1, 1,  1, 0);
        tv[2]  = mk(4'b1111, 16, 255, 1, 0,  2, 0, 4'b0100, 255, 2, 15, 0);
        tv[3]  = mk(4'b1111, 16, 255, 1, 0,  2, 0, 4'b1000,  16, 3,  4, 0);
        tv[4]  = mk(4'b1111, 16, 255, 1, 0,  2, 0, 4'b0001,   0, 0,  0, 0);
        tv[5]  = mk(4'b0100,  0, 200, 0, 0,  5, 0, 4'b0100, 200, 2, 14, 0);
        tv[6]  = mk(4'b1001,  9,   0, 0, 49, 3, 0, 4'b1000,   9, 3,  3, 0);
        tv[7]  = mk(4'b0001,  0,   0, 0, 49, 1, 0, 4'b0001,  49, 0,  7, 0);
        tv[8]  = mk(4'b0010,  0,   0, 100, 0, 0, 0, 4'b0010, 100, 1,  0, 1);
        tv[9]  = mk(4'b0110,  0,  81, 64, 0, 4, 0, 4'b0100,  81, 2,  9, 0);
        tv[10] = mk(4'b0001,  0,   0, 0, 225, 64, 1, 4'b0001, 225, 0, 15, 0);
        tv[11] = mk(4'b0010,  0,   0, 144, 0, 65, 0, 4'b0010, 144, 1,  0, 1);
        tv[12] = mk(4'b1011, 200,  0, 0, 0,  2, 0, 4'b1000, 200, 3, 14, 0);

        bus.req = '0;
        bus.req_x = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_gnt", bus.gnt, 0);
        check("rst_start", bus.eng_start, 0);
        check("rst_engx", bus.eng_x, 0);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_sqrt, bus.rsp_err}, 0);
        check("rst_busy", bus.busy, 0);
        Reset = 1'b1;

        // Reset during WAIT: job abandoned, pointer back to 0, no stale response.
        run_row("t1_pre", mk(4'b0100, 0, 4, 0, 0, 2, 0, 4'b0100, 4, 2, 2, 0), 1'b0);
        eng_delay = 0;
        @(posedge Clock); #1;
        bus.req = 4'b0001;
        bus.req_x = {8'd0, 8'd0, 8'd0, 8'd77};
        repeat (8) @(negedge Clock);
        check("t1_busy_before", bus.busy, 1);
        #2;
        Reset = 1'b0;
        bus.req = '0;
        #1;
        check("t1_async_rst", {bus.gnt, bus.eng_start, bus.eng_x, bus.rsp_valid, bus.rsp_id,
                               bus.rsp_sqrt, bus.rsp_err, bus.busy}, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        run_row("t1_after", mk(4'b1001, 9, 0, 0, 36, 2, 0, 4'b0001, 36, 0, 6, 0), 1'b0);

        @(negedge Clock);
        Reset = 1'b0;
        bus.req = '0;
        @(negedge Clock);
        Reset = 1'b1;
        for (int v = 0; v < 13; v++) run_row($sformatf("v%0d", v), tv[v], v > 0);

        // Randomized traffic against the round-robin reference model.
        @(negedge Clock);
        Reset = 1'b0;
        bus.req = '0;
        eng_early = 1'b0;
        eng_rnd = 1'b1;
        @(negedge Clock);
        Reset = 1'b1;
        rq = '0; rprev = '0; mptr = 0; oid = 0; ox = '0; out = 1'b0; grants = 0; rsps = 0;
        for (int i = 0; i < N; i++) xs[i] = '0;
        for (int cyc = 0; cyc < 2600; cyc++) begin
            @(posedge Clock); #1;
            for (int i = 0; i < N; i++) begin
                if (bus.gnt[i]) rq[i] = 1'b0;
                else if (!rq[i] && cyc < 2000 && $urandom_range(0, 3) == 0) begin
                    rq[i] = 1'b1;
                    xs[i] = W'($urandom);
                end
            end
            bus.req = rq;
            for (int i = 0; i < N; i++) bus.req_x[i*W +: W] = xs[i];
            @(negedge Clock);
            if (bus.gnt != '0) begin
                ei = pick(rprev, mptr);
                check("rnd_gnt", bus.gnt, (ei < 0) ? 0 : (1 << ei));
                check("rnd_one_job", out, 0);
                if (ei >= 0) begin
                    out = 1'b1;
                    oid = ei;
                    ox = xs[ei];
                    check("rnd_engx", bus.eng_x, ox);
                end
                grants++;
            end
            if (bus.rsp_valid) begin
                d = last_delay;
                check("rnd_rsp_expected", out, 1);
                check("rnd_rsp_id", bus.rsp_id, oid);
                check("rnd_rsp_sqrt", bus.rsp_sqrt, (d >= 1 && d <= TO) ? isqrt(int'(ox)) : 0);
                check("rnd_rsp_err", bus.rsp_err, (d >= 1 && d <= TO) ? 0 : 1);
                mptr = (oid + 1) % N;
                out = 1'b0;
                rsps++;
            end
            rprev = rq;
        end
        check("rnd_drained", out, 0);
        check("rnd_counts", rsps, grants);
        check("rnd_activity", grants > 10, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
